// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer slice.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2,
    ST_HALT  = 2'd3
  } pc_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC: sequential step, jump target and taken-branch target.
module pc_next
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  input  logic [25:0] jump_addr,
  input  logic [31:0] offset,
  output logic [31:0] pc4,
  output logic [31:0] target,
  output logic        redirect
);

  assign pc4 = pc + PC_STEP;

  // Jump outranks a taken branch; a non-taken branch falls through to pc4.
  always_comb begin
    target   = pc4;
    redirect = 1'b0;
    if (jump) begin
      target   = {pc4[31:28], jump_addr, 2'b00};
      redirect = 1'b1;
    end else if (branch && zero) begin
      target   = pc4 + {offset[29:0], 2'b00};
      redirect = 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: FSM, PC register, fetch timeout and decode handoff.
// Optional delay-slot behaviour is enabled by defining PC_SEQ_DELAY_SLOT_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [25:0] jump_addr,
  input  logic [31:0] offset,
  output logic [31:0] pc_value,
  output logic        fetch_err,
  output pc_state_e   state_dbg
);

  pc_state_e   state, state_next;
  logic [31:0] wait_cnt;
  logic [31:0] pc4, target, pc_load;
  logic        redirect;
  logic        handshake;
  logic        timeout;

  // Decode handshake: instr_valid stays high with instr_out stable until
  // instr_ready; the transfer happens in the cycle both are high.
  assign handshake = (state == ST_VALID) && instr_ready;
  assign timeout   = (WAIT_LIMIT != 0) && ((wait_cnt + 32'd1) == WAIT_LIMIT);
  assign imem_addr = pc_value;
  assign state_dbg = state;

  pc_next u_pc_next (
    .pc        (pc_value),
    .jump      (jump),
    .branch    (branch),
    .zero      (zero),
    .jump_addr (jump_addr),
    .offset    (offset),
    .pc4       (pc4),
    .target    (target),
    .redirect  (redirect)
  );

`ifdef PC_SEQ_DELAY_SLOT_EN
  logic        pend_valid;
  logic [31:0] pend_target;

  // A pending redirect is consumed at the delay-slot handshake, which itself
  // cannot redirect.
  assign pc_load = pend_valid ? pend_target : pc4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (handshake) begin
      if (pend_valid) begin
        pend_valid <= 1'b0;
      end else if (redirect) begin
        pend_valid  <= 1'b1;
        pend_target <= target;
      end
    end
  end
`else
  assign pc_load = redirect ? target : pc4;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      ST_IDLE:  if (run) state_next = ST_REQ;
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ack)     state_next = ST_VALID;
        else if (timeout) state_next = ST_HALT;
      end
      ST_VALID: if (instr_ready) state_next = run ? ST_REQ : ST_IDLE;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_value    <= RESET_PC;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      // Counter is zero whenever REQ is entered; HALT freezes it.
      if (state == ST_REQ && !imem_ack)  wait_cnt <= wait_cnt + 32'd1;
      else if (state != ST_HALT)         wait_cnt <= '0;

      if (state == ST_REQ && !imem_ack && timeout) fetch_err <= 1'b1;

      if (state == ST_REQ && imem_ack) begin
        instr_out   <= imem_rdata;
        instr_valid <= 1'b1;
      end else if (handshake) begin
        instr_valid <= 1'b0;
      end

      if (handshake) pc_value <= pc_load;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (WAIT_LIMIT=4); follows PC_SEQ_DELAY_SLOT_EN if defined.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_ready = 1'b0;
  logic        branch = 1'b0, zero = 1'b0, jump = 1'b0;
  logic [25:0] jump_addr = '0;
  logic [31:0] offset = '0;
  logic        imem_req, instr_valid, fetch_err;
  logic [31:0] imem_addr, instr_out, pc_value;
  pc_state_e   state_dbg;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  logic        pend_v;
  logic [31:0] pend_t;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0), .WAIT_LIMIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .offset      (offset),
    .pc_value    (pc_value),
    .fetch_err   (fetch_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [31:0] model_target(input logic [31:0] pc, input logic j, b, z,
                                               input logic [25:0] ja, input logic [31:0] off);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (j)          return {p4[31:28], ja, 2'b00};
    else if (b & z) return p4 + (off << 2);
    else            return p4;
  endfunction

  // ---------------- drivers ----------------
  task automatic noise();
    jump      = 1'($urandom_range(0, 1));
    branch    = 1'($urandom_range(0, 1));
    zero      = 1'($urandom_range(0, 1));
    jump_addr = 26'($urandom);
    offset    = $urandom;
  endtask

  task automatic quiet();
    jump = 1'b0; branch = 1'b0; zero = 1'b0; jump_addr = '0; offset = '0;
    instr_ready = 1'b0; imem_ack = 1'b0;
  endtask

  // Entered at a negedge with the DUT in REQ; leaves at the negedge after the handshake.
  task automatic fetch_one(input int ack_dly, input int rdy_dly, input logic j, b, z,
                           input logic [25:0] ja, input logic [31:0] off, input logic run_after);
    logic [31:0] data, nxt, tgt;
    check_eq("req_high", 32'(imem_req), 32'd1);
    check_eq("fetch_addr", imem_addr, model_pc);
    for (int i = 0; i < ack_dly; i++) begin
      noise();
      @(negedge clk);
      check_eq("addr_hold", imem_addr, model_pc);
    end
    quiet();
    data = $urandom;
    imem_ack = 1'b1;
    imem_rdata = data;
    exp_q.push_back(data);
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    for (int i = 0; i < rdy_dly; i++) begin
      check_eq("valid_hold", 32'(instr_valid), 32'd1);
      check_eq("instr_hold", instr_out, exp_q[0]);
      noise();
      imem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    quiet();
    check_eq("valid", 32'(instr_valid), 32'd1);
    check_eq("instr", instr_out, exp_q.pop_front());
    instr_ready = 1'b1;
    jump = j; branch = b; zero = z; jump_addr = ja; offset = off;
    run = run_after;
    tgt = model_target(model_pc, j, b, z, ja, off);
`ifdef PC_SEQ_DELAY_SLOT_EN
    if (pend_v) begin
      nxt = pend_t;
      pend_v = 1'b0;
    end else if (j | (b & z)) begin
      pend_v = 1'b1;
      pend_t = tgt;
      nxt = model_pc + 32'd4;
    end else begin
      nxt = tgt;
    end
`else
    nxt = tgt;
`endif
    @(negedge clk);
    quiet();
    model_pc = nxt;
    check_eq("valid_clr", 32'(instr_valid), 32'd0);
    check_eq("pc_next", pc_value, model_pc);
  endtask

  task automatic plain(input int ack_dly, input int rdy_dly);
    fetch_one(ack_dly, rdy_dly, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] seq_tab[3];

  initial begin
    seq_tab = '{32'd0, 32'd4, 32'd8};
    pend_v = 1'b0;
    pend_t = '0;
    model_pc = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_pc", pc_value, 32'h0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr_out, 32'h0);
    check_eq("rst_err", 32'(fetch_err), 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));

    rst = 1'b1;
    run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("seq_addr", imem_addr, seq_tab[i]);
      plain(0, 0);
    end
    check_eq("seq_addr", imem_addr, 32'd12);
    fetch_one(0, 0, 1'b1, 1'b0, 1'b0, 26'h2, '0, 1'b1);
`ifndef PC_SEQ_DELAY_SLOT_EN
    check_eq("jump_to_8", imem_addr, 32'd8);
`endif
    fetch_one(0, 1, 1'b0, 1'b1, 1'b1, '0, 32'hFFFF_FFFD, 1'b1);
`ifndef PC_SEQ_DELAY_SLOT_EN
    check_eq("branch_taken", imem_addr, 32'd0);
`endif
    fetch_one(1, 0, 1'b0, 1'b1, 1'b0, '0, 32'h0000_0010, 1'b1);
`ifndef PC_SEQ_DELAY_SLOT_EN
    check_eq("branch_not_taken", imem_addr, 32'd4);
`endif
    // Ack on the final allowed wait cycle must still complete the fetch.
    plain(3, 2);
    check_eq("no_err_boundary", 32'(fetch_err), 32'd0);

    fetch_one(0, 0, 1'b1, 1'b1, 1'b1, 26'h8, 32'h4, 1'b1);
`ifdef PC_SEQ_DELAY_SLOT_EN
    plain(0, 0);
`endif
    check_eq("at_0x20", imem_addr, 32'h20);
    fetch_one(0, 0, 1'b1, 1'b0, 1'b0, 26'h2, '0, 1'b1);
`ifdef PC_SEQ_DELAY_SLOT_EN
    check_eq("delay_slot", imem_addr, 32'h24);
    fetch_one(0, 0, 1'b1, 1'b1, 1'b1, 26'h3F, 32'h7, 1'b1);
`endif
    check_eq("jump_target", imem_addr, 32'h8);

    // Stop at handshake, then resume from IDLE.
    fetch_one(0, 0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    check_eq("idle_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);
    check_eq("idle_req", 32'(imem_req), 32'd0);
    run = 1'b1;
    @(negedge clk);
    check_eq("resume_addr", imem_addr, model_pc);
    plain(1, 1);

    // Reset in the middle of a fetch.
    rst = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'(imem_req), 32'd0);
    check_eq("mid_rst_pc", pc_value, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_pc = 32'h0;
    pend_v = 1'b0;
    @(negedge clk);
    check_eq("restart_addr", imem_addr, 32'h0);
    plain(0, 0);

    // Fetch timeout: no ack for WAIT_LIMIT REQ cycles.
    repeat (3) @(negedge clk);
    check_eq("pre_to_err", 32'(fetch_err), 32'd0);
    check_eq("pre_to_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    check_eq("to_err", 32'(fetch_err), 32'd1);
    check_eq("to_req", 32'(imem_req), 32'd0);
    check_eq("to_state", 32'(state_dbg), 32'(ST_HALT));
    for (int i = 0; i < 3; i++) begin
      noise();
      imem_ack = 1'b1;
      instr_ready = 1'b1;
      @(negedge clk);
      check_eq("halt_req", 32'(imem_req), 32'd0);
      check_eq("halt_pc", pc_value, 32'h4);
      check_eq("halt_err", 32'(fetch_err), 32'd1);
      check_eq("halt_valid", 32'(instr_valid), 32'd0);
    end
    quiet();
    rst = 1'b0;
    #1;
    check_eq("halt_rst_err", 32'(fetch_err), 32'd0);
    check_eq("halt_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
